// File: rtl/riscv_pkg.sv
// riscv_pkg
// Shared RV32 opcode constants and hazard-control types.
//   OP_*         : 7-bit base opcodes used by the operand-use decode
//   sb_entry_t   : destination scoreboard entry {valid, rd}
//   ctl_case_t   : which pipeline-control case is active this cycle
//   sb_hit()     : scoreboard entry matches a used, nonzero source register
package riscv_pkg;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
    } sb_entry_t;

    typedef enum logic [1:0] {
        CTL_NORMAL = 2'd0,
        CTL_RAW    = 2'd1,
        CTL_FLUSH  = 2'd2,
        CTL_BUSY   = 2'd3
    } ctl_case_t;

    function automatic logic sb_hit(sb_entry_t e, logic used, logic [4:0] rs);
        return used && (rs != 5'd0) && e.valid && (e.rd == rs);
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if
// Bundle between the pipeline datapath and the hazard controller.
//   i_id_instr, i_id_valid : instruction held in IF/ID and its valid flag
//   i_ex_pc_sel            : branch taken / jump resolved in EX
//   i_mem_busy             : data memory stall, freezes the whole pipe
//   o_pc_en, o_ifid_en     : PC and IF/ID load enables
//   o_ifid_flush           : clear IF/ID to a bubble at the next edge
//   o_idex_flush           : load a bubble into ID/EX at the next edge
//   o_exmem_en             : EX/MEM and MEM/WB load enable
//   o_stall_cnt/o_flush_cnt: saturating performance counters
// Modports: master = datapath side, slave = hazard_ctrl.
interface hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [31:0]      i_id_instr;
    logic             i_id_valid;
    logic             i_ex_pc_sel;
    logic             i_mem_busy;
    logic             o_pc_en;
    logic             o_ifid_en;
    logic             o_ifid_flush;
    logic             o_idex_flush;
    logic             o_exmem_en;
    logic [CNT_W-1:0] o_stall_cnt;
    logic [CNT_W-1:0] o_flush_cnt;

    modport master (
        output i_id_instr, i_id_valid, i_ex_pc_sel, i_mem_busy,
        input  o_pc_en, o_ifid_en, o_ifid_flush, o_idex_flush, o_exmem_en,
        input  o_stall_cnt, o_flush_cnt
    );

    modport slave (
        input  i_id_instr, i_id_valid, i_ex_pc_sel, i_mem_busy,
        output o_pc_en, o_ifid_en, o_ifid_flush, o_idex_flush, o_exmem_en,
        output o_stall_cnt, o_flush_cnt
    );
endinterface

// File: rtl/reg_use_decode.sv
// reg_use_decode
// Combinational operand-use decode of one RV32 base instruction.
//   instr    : 32-bit instruction word
//   rs1_used : instruction reads rs1
//   rs2_used : instruction reads rs2
//   rd_wr    : instruction writes a nonzero rd
//   rs1, rs2, rd : raw register fields
module reg_use_decode
    import riscv_pkg::*;
(
    input  logic [31:0] instr,
    output logic        rs1_used,
    output logic        rs2_used,
    output logic        rd_wr,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd
);
    logic [6:0] opcode;
    logic       writes_rd;
    logic       unused_bits;

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];

    // funct fields do not affect register usage
    assign unused_bits = ^{instr[31:25], instr[14:12]};

    always_comb begin
        rs1_used  = 1'b0;
        rs2_used  = 1'b0;
        writes_rd = 1'b0;
        case (opcode)
            OP_RTYPE:  begin rs1_used = 1'b1; rs2_used = 1'b1; writes_rd = 1'b1; end
            OP_ITYPE:  begin rs1_used = 1'b1; writes_rd = 1'b1; end
            OP_LOAD:   begin rs1_used = 1'b1; writes_rd = 1'b1; end
            OP_STORE:  begin rs1_used = 1'b1; rs2_used = 1'b1; end
            OP_BRANCH: begin rs1_used = 1'b1; rs2_used = 1'b1; end
            OP_JALR:   begin rs1_used = 1'b1; writes_rd = 1'b1; end
            OP_JAL:    writes_rd = 1'b1;
            OP_LUI:    writes_rd = 1'b1;
            OP_AUIPC:  writes_rd = 1'b1;
            default:   ;
        endcase
    end

    // x0 is hardwired, so writing it never creates a dependency
    assign rd_wr = writes_rd && (rd != 5'd0);

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
// Five-stage pipeline hazard controller: RAW interlock against a 3-entry
// destination scoreboard (EX, MEM, WB), control-flush on EX redirect, and
// global freeze on data-memory busy. Control outputs are combinational;
// the scoreboard and two saturating counters are registered.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   bus (slave)    : see hazard_ctrl_if
// Build option: WB_BYPASS_EN -- register file is write-through, so the WB
// entry is left out of the RAW compare.
module hazard_ctrl
    import riscv_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    hazard_ctrl_if.slave  bus
);
    logic             rs1_used, rs2_used, rd_wr;
    logic [4:0]       rs1, rs2, rd;
    sb_entry_t        sb_ex, sb_mem, sb_wb;
    logic             raw;
    ctl_case_t        ctl;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    reg_use_decode u_dec (
        .instr    (bus.i_id_instr),
        .rs1_used (rs1_used),
        .rs2_used (rs2_used),
        .rd_wr    (rd_wr),
        .rs1      (rs1),
        .rs2      (rs2),
        .rd       (rd)
    );

`ifdef WB_BYPASS_EN
    logic unused_wb;
    assign unused_wb = ^sb_wb;
    assign raw = bus.i_id_valid &&
                 (sb_hit(sb_ex,  rs1_used, rs1) || sb_hit(sb_ex,  rs2_used, rs2) ||
                  sb_hit(sb_mem, rs1_used, rs1) || sb_hit(sb_mem, rs2_used, rs2));
`else
    assign raw = bus.i_id_valid &&
                 (sb_hit(sb_ex,  rs1_used, rs1) || sb_hit(sb_ex,  rs2_used, rs2) ||
                  sb_hit(sb_mem, rs1_used, rs1) || sb_hit(sb_mem, rs2_used, rs2) ||
                  sb_hit(sb_wb,  rs1_used, rs1) || sb_hit(sb_wb,  rs2_used, rs2));
`endif

    always_comb begin
        if (bus.i_mem_busy)       ctl = CTL_BUSY;
        else if (bus.i_ex_pc_sel) ctl = CTL_FLUSH;
        else if (raw)             ctl = CTL_RAW;
        else                      ctl = CTL_NORMAL;
    end

    always_comb begin
        bus.o_pc_en      = 1'b1;
        bus.o_ifid_en    = 1'b1;
        bus.o_ifid_flush = 1'b0;
        bus.o_idex_flush = 1'b0;
        bus.o_exmem_en   = 1'b1;
        case (ctl)
            CTL_BUSY: begin
                bus.o_pc_en    = 1'b0;
                bus.o_ifid_en  = 1'b0;
                bus.o_exmem_en = 1'b0;
            end
            CTL_FLUSH: begin
                bus.o_ifid_flush = 1'b1;
                bus.o_idex_flush = 1'b1;
            end
            CTL_RAW: begin
                bus.o_pc_en      = 1'b0;
                bus.o_ifid_en    = 1'b0;
                bus.o_idex_flush = 1'b1;
            end
            default: ;
        endcase
    end

    // Scoreboard shifts in lockstep with the pipeline registers; a stalled
    // or flushed ID stage injects a bubble, so EX only tracks a real write.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sb_ex  <= '0;
            sb_mem <= '0;
            sb_wb  <= '0;
        end else if (ctl != CTL_BUSY) begin
            sb_wb  <= sb_mem;
            sb_mem <= sb_ex;
            if (ctl == CTL_NORMAL && bus.i_id_valid && rd_wr)
                sb_ex <= {1'b1, rd};
            else
                sb_ex <= '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (ctl == CTL_RAW && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (ctl == CTL_FLUSH && flush_cnt != '1)
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

    assign bus.o_stall_cnt = stall_cnt;
    assign bus.o_flush_cnt = flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

`ifdef WB_BYPASS_EN
    localparam int NS = 2;
`else
    localparam int NS = 3;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   exp_stall = 0;
    int   exp_flush = 0;

    always #5 clk = ~clk;

    hazard_ctrl_if #(.CNT_W(32)) hz ();
    hazard_ctrl_if #(.CNT_W(4))  hz4 ();

    hazard_ctrl #(.CNT_W(32)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(hz.slave));
    hazard_ctrl #(.CNT_W(4))  dut4 (.i_clk(clk), .i_rst_n(rst_n), .bus(hz4.slave));

    assign hz4.i_id_instr  = hz.i_id_instr;
    assign hz4.i_id_valid  = hz.i_id_valid;
    assign hz4.i_ex_pc_sel = hz.i_ex_pc_sel;
    assign hz4.i_mem_busy  = hz.i_mem_busy;

    function automatic logic [31:0] enc_r(logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_i(logic [4:0] rd, logic [4:0] rs1, logic [11:0] imm);
        return {imm, rs1, 3'b000, rd, 7'b0010011};
    endfunction
    function automatic logic [31:0] enc_lui(logic [4:0] rd);
        return {20'h00001, rd, 7'b0110111};
    endfunction
    function automatic logic [31:0] enc_sw(logic [4:0] rs2, logic [4:0] rs1);
        return {7'b0, rs2, rs1, 3'b010, 5'b0, 7'b0100011};
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_ctl(string tag, logic pc, logic ifid, logic ifl, logic idfl, logic exm);
        check({tag, ".pc_en"},      32'(hz.o_pc_en),      32'(pc));
        check({tag, ".ifid_en"},    32'(hz.o_ifid_en),    32'(ifid));
        check({tag, ".ifid_flush"}, 32'(hz.o_ifid_flush), 32'(ifl));
        check({tag, ".idex_flush"}, 32'(hz.o_idex_flush), 32'(idfl));
        check({tag, ".exmem_en"},   32'(hz.o_exmem_en),   32'(exm));
    endtask

    task automatic check_cnt(string tag);
        check({tag, ".stall_cnt"}, hz.o_stall_cnt, 32'(exp_stall));
        check({tag, ".flush_cnt"}, hz.o_flush_cnt, 32'(exp_flush));
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 ns later.
    task automatic drive(logic [31:0] instr, logic v, logic sel, logic busy);
        @(negedge clk);
        hz.i_id_instr  = instr;
        hz.i_id_valid  = v;
        hz.i_ex_pc_sel = sel;
        hz.i_mem_busy  = busy;
        #1;
    endtask

    task automatic drain();
        repeat (3) drive(32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic raw_pair();
        drive(enc_i(5'd5, 5'd0, 12'd1), 1'b1, 1'b0, 1'b0);
        repeat (NS + 1) drive(enc_r(5'd6, 5'd5, 5'd5), 1'b1, 1'b0, 1'b0);
        drain();
    endtask

    initial begin
        hz.i_id_instr  = 32'h0;
        hz.i_id_valid  = 1'b0;
        hz.i_ex_pc_sel = 1'b0;
        hz.i_mem_busy  = 1'b0;
        #1;
        check_ctl("rst", 1, 1, 0, 0, 1);
        check_cnt("rst");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_ctl("post_rst", 1, 1, 0, 0, 1);

        // addi x5,x0,1 ; add x6,x5,x5
        drive(enc_i(5'd5, 5'd0, 12'd1), 1'b1, 1'b0, 1'b0);
        check_ctl("s1.addi", 1, 1, 0, 0, 1);
        for (int i = 0; i < NS; i++) begin
            drive(enc_r(5'd6, 5'd5, 5'd5), 1'b1, 1'b0, 1'b0);
            check_ctl($sformatf("s1.stall%0d", i), 0, 0, 0, 1, 1);
        end
        drive(enc_r(5'd6, 5'd5, 5'd5), 1'b1, 1'b0, 1'b0);
        exp_stall = NS;
        check_ctl("s1.go", 1, 1, 0, 0, 1);
        check_cnt("s1");
        check("s1.cnt4", 32'(hz4.o_stall_cnt), 32'(NS));
        drain();

        // add x0,x1,x2 ; add x3,x0,x0
        drive(enc_r(5'd0, 5'd1, 5'd2), 1'b1, 1'b0, 1'b0);
        check_ctl("s2.add_x0", 1, 1, 0, 0, 1);
        drive(enc_r(5'd3, 5'd0, 5'd0), 1'b1, 1'b0, 1'b0);
        check_ctl("s2.use_x0", 1, 1, 0, 0, 1);
        drain();
        check_cnt("s2");

        // dependent instruction in ID is invalid -> no interlock
        drive(enc_i(5'd5, 5'd0, 12'd1), 1'b1, 1'b0, 1'b0);
        drive(enc_r(5'd6, 5'd5, 5'd5), 1'b0, 1'b0, 1'b0);
        check_ctl("s7.bubble", 1, 1, 0, 0, 1);
        drain();

        // taken branch in EX with a dependent instruction in ID
        drive(enc_i(5'd5, 5'd0, 12'd1), 1'b1, 1'b0, 1'b0);
        drive(enc_r(5'd6, 5'd5, 5'd5), 1'b1, 1'b1, 1'b0);
        check_ctl("s3.flush", 1, 1, 1, 1, 1);
        drive(32'h0, 1'b0, 1'b0, 1'b0);
        exp_flush = 1;
        check_cnt("s3");
        drain();

        // mem_busy for 4 cycles in the middle of a pending stall
        drive(enc_i(5'd5, 5'd0, 12'd1), 1'b1, 1'b0, 1'b0);
        drive(enc_r(5'd6, 5'd5, 5'd5), 1'b1, 1'b0, 1'b0);
        check_ctl("s4.stall0", 0, 0, 0, 1, 1);
        for (int i = 0; i < 4; i++) begin
            // last busy cycle also raises pc_sel: busy must still win
            drive(enc_r(5'd6, 5'd5, 5'd5), 1'b1, (i == 3), 1'b1);
            check_ctl($sformatf("s4.busy%0d", i), 0, 0, 0, 0, 0);
        end
        exp_stall = exp_stall + 1;
        check_cnt("s4.busy");
        for (int i = 1; i < NS; i++) begin
            drive(enc_r(5'd6, 5'd5, 5'd5), 1'b1, 1'b0, 1'b0);
            check_ctl($sformatf("s4.stall%0d", i), 0, 0, 0, 1, 1);
        end
        drive(enc_r(5'd6, 5'd5, 5'd5), 1'b1, 1'b0, 1'b0);
        exp_stall = exp_stall + NS - 1;
        check_ctl("s4.go", 1, 1, 0, 0, 1);
        check_cnt("s4");
        drain();

        // lui x7 ; sw x7,0(x0) stalls on rs2, then reset mid-stall
        drive(enc_lui(5'd7), 1'b1, 1'b0, 1'b0);
        drive(enc_sw(5'd7, 5'd0), 1'b1, 1'b0, 1'b0);
        check_ctl("s5.stall", 0, 0, 0, 1, 1);
        #2;
        rst_n = 1'b0;
        #1;
        exp_stall = 0;
        exp_flush = 0;
        check_ctl("s5.rst", 1, 1, 0, 0, 1);
        check_cnt("s5.rst");
        check("s5.rst_cnt4", 32'(hz4.o_stall_cnt), 32'd0);
        @(posedge clk);
        #1;
        check_ctl("s5.rst_edge", 1, 1, 0, 0, 1);
        rst_n = 1'b1;
        drive(enc_sw(5'd7, 5'd0), 1'b1, 1'b0, 1'b0);
        check_ctl("s5.after", 1, 1, 0, 0, 1);
        check_cnt("s5.after");
        drain();

        // 8 back-to-back RAW pairs: the 4-bit counter must saturate
        repeat (8) raw_pair();
        exp_stall = 8 * NS;
        check_cnt("s6");
        check("s6.cnt4_sat", 32'(hz4.o_stall_cnt), 32'd15);
        raw_pair();
        exp_stall = 9 * NS;
        check_cnt("s6.more");
        check("s6.cnt4_hold", 32'(hz4.o_stall_cnt), 32'd15);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
